// File: rtl/reg_lock_pkg.sv
// reg_lock_pkg: state encoding and shared widths for the register lock controller
package reg_lock_pkg;
    typedef enum logic [1:0] {LOCKED, KEY1_WAIT, UNLOCKED, LOCKOUT} lock_state_t;
    localparam int FAIL_W  = 3;
    localparam int TIMER_W = 8;
endpackage

// File: rtl/reg_lock_ctrl_timer.sv
// lock_timer: loadable down-counter; zero_o flags the last live cycle of a window
module lock_timer
    import reg_lock_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic               zero_o
);
    logic [TIMER_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/reg_lock_ctrl.sv
// reg_lock_ctrl: two-word key lock gating register-bank write enables, with idle relock and lockout
module reg_lock_ctrl
    import reg_lock_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                NUM_REGS = 4,
    parameter int                ADDR_W   = 2,
    parameter logic [DATA_W-1:0] KEY0     = 8'hA5,
    parameter logic [DATA_W-1:0] KEY1     = 8'h5A,
    parameter int                TIMEOUT  = 16,
    parameter int                MAX_FAIL = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                key_valid,
    input  logic [DATA_W-1:0]   key_data,
    input  logic                lock_req,
    input  logic                wr_valid,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [NUM_REGS-1:0] reg_we,
    output logic [DATA_W-1:0]   reg_wdata,
    output logic                wr_ack,
    output logic                wr_err,
    output logic                unlocked,
    output logic                lockout,
    output logic [FAIL_W-1:0]   fail_cnt
);
    localparam logic [ADDR_W:0]  REG_LIMIT = (ADDR_W+1)'(NUM_REGS);
    localparam logic [FAIL_W-1:0] MAX_F    = FAIL_W'(MAX_FAIL);
    // Loading TIMEOUT-1 makes the zero flag coincide with the final cycle before relock
    localparam logic [TIMER_W-1:0] TMR_INIT = TIMER_W'(TIMEOUT - 1);

    lock_state_t         state_q, state_d;
    logic [FAIL_W-1:0]   fail_q, fail_d, fail_inc;
    logic [NUM_REGS-1:0] we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ack_q, err_q;
    logic                fail_ev, accept, tmr_load, tmr_dec, tmr_zero;

    lock_timer u_timer (
        .clk       (clk),
        .resetn    (resetn),
        .load_i    (tmr_load),
        .load_val_i(TMR_INIT),
        .dec_i     (tmr_dec),
        .zero_o    (tmr_zero)
    );

    assign accept   = state_q == UNLOCKED && wr_valid && !lock_req && {1'b0, wr_addr} < REG_LIMIT;
    assign fail_inc = (fail_q == MAX_F) ? fail_q : fail_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        fail_ev  = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            LOCKED:
                if (key_valid) begin
                    if (key_data == KEY0) begin
                        state_d  = KEY1_WAIT;
                        tmr_load = 1'b1;
                    end else fail_ev = 1'b1;
                end
            KEY1_WAIT:
                if (lock_req) state_d = LOCKED;
                else if (key_valid) begin
                    if (key_data == KEY1) begin
                        state_d  = UNLOCKED;
                        tmr_load = 1'b1;
                        fail_d   = '0;
                    end else begin
                        state_d = LOCKED;
                        fail_ev = 1'b1;
                    end
                end else if (tmr_zero) begin
                    state_d = LOCKED;
                    fail_ev = 1'b1;
                end else tmr_dec = 1'b1;
            UNLOCKED:
                if (lock_req) state_d = LOCKED;
                else if (accept) tmr_load = 1'b1;
                else if (tmr_zero) state_d = LOCKED;
                else tmr_dec = 1'b1;
            LOCKOUT: ;
        endcase
        if (fail_ev) begin
            fail_d = fail_inc;
            if (fail_inc == MAX_F) state_d = LOCKOUT;
        end
    end

    always_comb begin
        we_d    = accept ? NUM_REGS'(1) << wr_addr : '0;
        wdata_d = accept ? wr_data : wdata_q;
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state_q <= LOCKED;
            fail_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ack_q   <= accept;
            err_q   <= wr_valid && !accept;
        end

    assign reg_we    = we_q;
    assign reg_wdata = wdata_q;
    assign wr_ack    = ack_q;
    assign wr_err    = err_q;
    assign unlocked  = state_q == UNLOCKED;
    assign lockout   = state_q == LOCKOUT;
    assign fail_cnt  = fail_q;
endmodule

// File: tb/tb_reg_lock_ctrl.sv
// tb_reg_lock_ctrl: vector table, corner sequences and random traffic against a deadline-based model
module tb_reg_lock_ctrl;
    localparam int NREGS = 3;
    localparam int T     = 16;
    localparam int MAXF  = 3;
    localparam logic [7:0] K0 = 8'hA5;
    localparam logic [7:0] K1 = 8'h5A;
    localparam int M_L = 0, M_W = 1, M_U = 2, M_LO = 3;

    logic clk = 1'b0, resetn = 1'b0;
    logic key_valid = 1'b0, lock_req = 1'b0, wr_valid = 1'b0;
    logic [7:0] key_data = '0, wr_data = '0;
    logic [1:0] wr_addr = '0;
    logic [NREGS-1:0] reg_we;
    logic [7:0] reg_wdata;
    logic wr_ack, wr_err, unlocked, lockout;
    logic [2:0] fail_cnt;

    reg_lock_ctrl #(.NUM_REGS(NREGS), .TIMEOUT(T), .MAX_FAIL(MAXF)) dut (
        .clk(clk), .resetn(resetn), .key_valid(key_valid), .key_data(key_data),
        .lock_req(lock_req), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .reg_we(reg_we), .reg_wdata(reg_wdata), .wr_ack(wr_ack), .wr_err(wr_err),
        .unlocked(unlocked), .lockout(lockout), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int ms, mcyc, mdl;
    logic [2:0] mfail, mwe;
    logic [7:0] mwd;
    logic mack, merr;

    typedef struct {
        logic kv; logic [7:0] kd; logic lr; logic wv; logic [1:0] wa; logic [7:0] wd;
        logic [2:0] we; logic [7:0] wdata; logic ack; logic err; logic unl; logic lo; logic [2:0] fail;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic kv, input logic [7:0] kd, input logic lr,
                         input logic wv, input logic [1:0] wa, input logic [7:0] wd);
        key_valid = kv; key_data = kd; lock_req = lr; wr_valid = wv; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic kv, input logic [7:0] kd, input logic lr,
                         input logic wv, input logic [1:0] wa, input logic [7:0] wd);
        bit acc, fail;
        acc  = ms == M_U && wv && !lr && int'(wa) < NREGS;
        fail = 0;
        mwe  = acc ? 3'(1 << wa) : 3'd0;
        if (acc) mwd = wd;
        mack = acc;
        merr = wv && !acc;
        if (ms == M_L && kv) begin
            if (kd == K0) begin ms = M_W; mdl = mcyc + T; end
            else fail = 1;
        end else if (ms == M_W) begin
            if (lr) ms = M_L;
            else if (kv && kd == K1) begin ms = M_U; mdl = mcyc + T; mfail = 0; end
            else if (kv || mcyc == mdl) begin ms = M_L; fail = 1; end
        end else if (ms == M_U) begin
            if (lr) ms = M_L;
            else if (acc) mdl = mcyc + T;
            else if (mcyc == mdl) ms = M_L;
        end
        if (fail) begin
            if (int'(mfail) < MAXF) mfail = mfail + 3'd1;
            if (int'(mfail) == MAXF) ms = M_LO;
        end
        mcyc++;
    endtask

    task automatic check_all();
        chk("reg_we", reg_we, mwe);
        chk("reg_wdata", reg_wdata, mwd);
        chk("wr_ack", wr_ack, mack);
        chk("wr_err", wr_err, merr);
        chk("unlocked", unlocked, ms == M_U);
        chk("lockout", lockout, ms == M_LO);
        chk("fail_cnt", fail_cnt, mfail);
    endtask

    task automatic step(input logic kv, input logic [7:0] kd, input logic lr,
                        input logic wv, input logic [1:0] wa, input logic [7:0] wd);
        drive(kv, kd, lr, wv, wa, wd);
        model(kv, kd, lr, wv, wa, wd);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 2'd0, 8'h00);
    endtask

    task automatic do_reset();
        key_valid = 0; lock_req = 0; wr_valid = 0;
        resetn = 1'b0;
        #1;
        chk("rst_reg_we", reg_we, 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_unlocked", unlocked, 0);
        chk("rst_lockout", lockout, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        ms = M_L; mfail = 0; mwe = 0; mwd = 0; mack = 0; merr = 0; mcyc = 0; mdl = 0;
    endtask

    initial begin
        tbl[0]  = '{0, 8'h00, 0, 1, 2'd1, 8'h11, 3'b000, 8'h00, 0, 1, 0, 0, 3'd0};
        tbl[1]  = '{1, K0,    0, 0, 2'd0, 8'h00, 3'b000, 8'h00, 0, 0, 0, 0, 3'd0};
        tbl[2]  = '{1, K1,    0, 0, 2'd0, 8'h00, 3'b000, 8'h00, 0, 0, 1, 0, 3'd0};
        tbl[3]  = '{0, 8'h00, 0, 1, 2'd2, 8'h3C, 3'b100, 8'h3C, 1, 0, 1, 0, 3'd0};
        tbl[4]  = '{1, 8'h00, 0, 1, 2'd0, 8'h12, 3'b001, 8'h12, 1, 0, 1, 0, 3'd0};
        tbl[5]  = '{0, 8'h00, 0, 1, 2'd3, 8'h77, 3'b000, 8'h12, 0, 1, 1, 0, 3'd0};
        tbl[6]  = '{0, 8'h00, 1, 1, 2'd0, 8'h55, 3'b000, 8'h12, 0, 1, 0, 0, 3'd0};
        tbl[7]  = '{1, 8'h00, 0, 0, 2'd0, 8'h00, 3'b000, 8'h12, 0, 0, 0, 0, 3'd1};
        tbl[8]  = '{1, 8'h11, 0, 0, 2'd0, 8'h00, 3'b000, 8'h12, 0, 0, 0, 0, 3'd2};
        tbl[9]  = '{1, K0,    0, 0, 2'd0, 8'h00, 3'b000, 8'h12, 0, 0, 0, 0, 3'd2};
        tbl[10] = '{1, 8'hFF, 0, 0, 2'd0, 8'h00, 3'b000, 8'h12, 0, 0, 0, 1, 3'd3};
        tbl[11] = '{1, K0,    0, 0, 2'd0, 8'h00, 3'b000, 8'h12, 0, 0, 0, 1, 3'd3};
        tbl[12] = '{1, K1,    0, 1, 2'd0, 8'h66, 3'b000, 8'h12, 0, 1, 0, 1, 3'd3};
        tbl[13] = '{0, 8'h00, 0, 1, 2'd2, 8'h99, 3'b000, 8'h12, 0, 1, 0, 1, 3'd3};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].kv, tbl[i].kd, tbl[i].lr, tbl[i].wv, tbl[i].wa, tbl[i].wd);
            chk($sformatf("tbl%0d_reg_we", i), reg_we, tbl[i].we);
            chk($sformatf("tbl%0d_reg_wdata", i), reg_wdata, tbl[i].wdata);
            chk($sformatf("tbl%0d_wr_ack", i), wr_ack, tbl[i].ack);
            chk($sformatf("tbl%0d_wr_err", i), wr_err, tbl[i].err);
            chk($sformatf("tbl%0d_unlocked", i), unlocked, tbl[i].unl);
            chk($sformatf("tbl%0d_lockout", i), lockout, tbl[i].lo);
            chk($sformatf("tbl%0d_fail_cnt", i), fail_cnt, tbl[i].fail);
        end

        do_reset();
        step(1, K0, 0, 0, 2'd0, 8'h00);
        step(1, K1, 0, 0, 2'd0, 8'h00);
        chk("to_unl_start", unlocked, 1);
        idle(15);
        chk("to_unl_c16", unlocked, 1);
        idle(1);
        chk("to_unl_c17", unlocked, 0);

        step(1, K0, 0, 0, 2'd0, 8'h00);
        step(1, K1, 0, 0, 2'd0, 8'h00);
        idle(15);
        step(0, 8'h00, 0, 1, 2'd0, 8'hC3);
        chk("to_reload_ack", wr_ack, 1);
        chk("to_reload_unl", unlocked, 1);
        idle(15);
        chk("to_reload_c16", unlocked, 1);
        idle(1);
        chk("to_reload_c17", unlocked, 0);

        step(1, K0, 0, 0, 2'd0, 8'h00);
        idle(15);
        step(1, K1, 0, 0, 2'd0, 8'h00);
        chk("gap_max_unl", unlocked, 1);
        step(0, 8'h00, 1, 0, 2'd0, 8'h00);
        step(1, K0, 0, 0, 2'd0, 8'h00);
        idle(15);
        chk("gap_exp_c16_fail", fail_cnt, 0);
        idle(1);
        chk("gap_exp_c17_fail", fail_cnt, 1);

        do_reset();
        step(1, 8'h00, 0, 0, 2'd0, 8'h00);
        step(0, 8'h00, 0, 1, 2'd1, 8'h44);
        step(1, K0, 0, 1, 2'd0, 8'h45);
        chk("mid_wait_err", wr_err, 1);
        do_reset();
        step(1, K1, 0, 0, 2'd0, 8'h00);
        chk("after_rst_not_unl", unlocked, 0);

        do_reset();
        step(1, K0, 0, 0, 2'd0, 8'h00);
        step(1, K1, 0, 0, 2'd0, 8'h00);
        step(0, 8'h00, 0, 1, 2'd1, 8'hB7);
        chk("unl_rst_we_live", reg_we, 3'b010);
        do_reset();

        for (int i = 0; i < 800; i++) begin
            logic [7:0] kd;
            int sel;
            if ((ms == M_LO && $urandom_range(0, 7) == 0) || i % 150 == 149) do_reset();
            sel = $urandom_range(0, 3);
            kd  = sel == 0 ? K0 : sel == 1 ? K1 : 8'($urandom);
            step($urandom_range(0, 3) == 0, kd, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
